// File: rtl/sdram_arb_pkg.sv
// Shared types and default timing for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} arb_state_t;
    typedef enum logic {PORT_A, PORT_B} port_id_t;

    localparam int DEF_CMD_CYCLES = 2;
    localparam int DEF_DATA_LAT   = 6;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner select for the SDRAM arbiter: fixed priority to A, B forced after
// STARVE_MAX consecutive A grants made while B was waiting.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_idle,
    input  logic i_a_req,
    input  logic i_b_req,
    output logic o_pick_b
);

    localparam int CNT_W = $clog2(STARVE_MAX + 2);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign o_pick_b  = i_b_req && (!i_a_req || w_starved);

    // Only IDLE cycles change the count: a grant happens there, and an idle
    // cycle without a pending B request forgets any earlier starvation.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else if (i_idle) begin
            if (!i_b_req || o_pick_b) begin
                r_starve_cnt <= '0;
            end else if (i_a_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Shares the single SDRAM port between CPU port A and DMA port B.
// Define SDRAM_ARB_WP_EN to block port A writes at or above WP_BASE.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int CMD_CYCLES = DEF_CMD_CYCLES,
    parameter int DATA_LAT   = DEF_DATA_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
`ifdef SDRAM_ARB_WP_EN
    ,
    parameter logic [ADDR_W-1:0] WP_BASE = ADDR_W'(17'h1_0000)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_dout,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_dout,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              wp_hit
);

    localparam int LAT_W = $clog2(DATA_LAT + 2);

    arb_state_t        r_state, w_state_nx;
    port_id_t          r_win, w_win_nx;
    logic              r_we, w_we_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [DATA_W-1:0] r_din, w_din_nx;
    logic [DATA_W-1:0] r_a_dout, w_a_dout_nx, r_b_dout, w_b_dout_nx;
    logic [LAT_W-1:0]  r_lat, w_lat_nx;
    logic              r_oe, w_oe_nx, r_mwe, w_mwe_nx;
    logic              r_a_ack, w_a_ack_nx, r_b_ack, w_b_ack_nx;
    logic              r_busy;
    logic              w_idle, w_pick_b, w_sel_we, w_blk_sel, w_blk_cur, w_sample;

    assign w_idle   = (r_state == IDLE);
    assign w_sel_we = w_pick_b ? b_we : a_we;

    sdram_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_idle   (w_idle),
        .i_a_req  (a_req),
        .i_b_req  (b_req),
        .o_pick_b (w_pick_b)
    );

`ifdef SDRAM_ARB_WP_EN
    logic r_wp_blk, r_wp_hit;

    assign w_blk_sel = !w_pick_b && a_we && (a_addr >= WP_BASE);
    assign w_blk_cur = r_wp_blk;
    assign wp_hit    = r_wp_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp_blk <= 1'b0;
            r_wp_hit <= 1'b0;
        end else begin
            if (w_idle) r_wp_blk <= w_blk_sel;
            r_wp_hit <= w_sample && r_wp_blk;
        end
    end
`else
    assign w_blk_sel = 1'b0;
    assign w_blk_cur = 1'b0;
    assign wp_hit    = 1'b0;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_win_nx    = r_win;
        w_we_nx     = r_we;
        w_addr_nx   = r_addr;
        w_din_nx    = r_din;
        w_lat_nx    = r_lat;
        w_oe_nx     = 1'b0;
        w_mwe_nx    = 1'b0;
        w_a_ack_nx  = 1'b0;
        w_b_ack_nx  = 1'b0;
        w_a_dout_nx = r_a_dout;
        w_b_dout_nx = r_b_dout;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (a_req || b_req) begin
                    w_win_nx   = w_pick_b ? PORT_B : PORT_A;
                    w_we_nx    = w_sel_we;
                    w_addr_nx  = w_pick_b ? b_addr : a_addr;
                    w_din_nx   = w_pick_b ? b_din : a_din;
                    w_lat_nx   = '0;
                    w_oe_nx    = !w_sel_we;
                    w_mwe_nx   = w_sel_we && !w_blk_sel;
                    w_state_nx = CMD;
                end
            end
            CMD: begin
                w_lat_nx = r_lat + LAT_W'(1);
                // r_lat counts strobe cycles from 0; the last one drops the strobe
                if (r_lat == LAT_W'(CMD_CYCLES - 1)) begin
                    if (DATA_LAT == CMD_CYCLES) begin
                        w_sample   = 1'b1;
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = WAIT;
                    end
                end else begin
                    w_oe_nx  = !r_we;
                    w_mwe_nx = r_we && !w_blk_cur;
                end
            end
            WAIT: begin
                w_lat_nx = r_lat + LAT_W'(1);
                if (r_lat == LAT_W'(DATA_LAT - 1)) begin
                    w_sample   = 1'b1;
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
        endcase
        if (w_sample) begin
            if (r_win == PORT_B) w_b_ack_nx = 1'b1;
            else                 w_a_ack_nx = 1'b1;
            if (!r_we) begin
                if (r_win == PORT_B) w_b_dout_nx = mem_dout;
                else                 w_a_dout_nx = mem_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_win    <= PORT_A;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_lat    <= '0;
            r_oe     <= 1'b0;
            r_mwe    <= 1'b0;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_a_dout <= '0;
            r_b_dout <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_win    <= w_win_nx;
            r_we     <= w_we_nx;
            r_addr   <= w_addr_nx;
            r_din    <= w_din_nx;
            r_lat    <= w_lat_nx;
            r_oe     <= w_oe_nx;
            r_mwe    <= w_mwe_nx;
            r_a_ack  <= w_a_ack_nx;
            r_b_ack  <= w_b_ack_nx;
            r_a_dout <= w_a_dout_nx;
            r_b_dout <= w_b_dout_nx;
            r_busy   <= (w_state_nx != IDLE);
        end
    end

    assign a_ack    = r_a_ack;
    assign b_ack    = r_b_ack;
    assign a_dout   = r_a_dout;
    assign b_dout   = r_b_dout;
    assign mem_oe   = r_oe;
    assign mem_we   = r_mwe;
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign busy     = r_busy;

endmodule
